// File: rtl/and4_selftest_ctrl_if.sv
// Control and gate-side signal bundle of the 4-input AND self-test sequencer.
// The sequencer connects through the slave view; the launcher and gate side use master.
interface and4_selftest_ctrl_if;
    logic       start;
    logic       dut_a;
    logic       dut_b;
    logic       dut_c;
    logic       dut_d;
    logic       dut_f;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       fail_valid;
    logic [3:0] first_fail;

    modport slave (
        input  start,
        input  dut_f,
        output dut_a,
        output dut_b,
        output dut_c,
        output dut_d,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_valid,
        output first_fail
    );

    modport master (
        output start,
        output dut_f,
        input  dut_a,
        input  dut_b,
        input  dut_c,
        input  dut_d,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_valid,
        input  first_fail
    );
endinterface

// File: rtl/and4_selftest_ctrl.sv
// Self-test sequencer for a 4-input AND gate: walks all 16 input vectors, holds
// each for SETTLE_CYCLES extra cycles, then compares and records the result.
module and4_selftest_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    and4_selftest_ctrl_if.slave          bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    function automatic logic expected_and(input logic [3:0] v);
        return &v;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic       fail_valid_q, fail_valid_d;
    logic [3:0] first_fail_q, first_fail_d;
    logic       pass_q, pass_d;
    logic [3:0] dut_q, dut_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Next-state, result bookkeeping and next output values.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_APPLY;
                    vec_d        = 4'd0;
                    cnt_d        = 4'd0;
                    err_d        = 5'd0;
                    fail_valid_d = 1'b0;
                    first_fail_d = 4'd0;
                    pass_d       = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (cnt_q != SETTLE) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    if (bus.dut_f != expected_and(vec_q)) begin
                        err_d = err_q + 5'd1;
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            first_fail_d = vec_q;
                        end else begin
                            fail_valid_d = fail_valid_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    cnt_d = 4'd0;
                    if (vec_q != 4'd15) begin
                        vec_d = vec_q + 4'd1;
                    end else begin
                        state_d = ST_DONE;
                        pass_d  = (err_d == 5'd0);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from the next state so they line up with it.
        dut_d  = (state_d == ST_APPLY) ? vec_d : 4'd0;
        busy_d = (state_d == ST_APPLY);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= 4'd0;
            cnt_q        <= 4'd0;
            err_q        <= 5'd0;
            fail_valid_q <= 1'b0;
            first_fail_q <= 4'd0;
            pass_q       <= 1'b0;
            dut_q        <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
            dut_q        <= dut_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.dut_a      = dut_q[0];
    assign bus.dut_b      = dut_q[1];
    assign bus.dut_c      = dut_q[2];
    assign bus.dut_d      = dut_q[3];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;
endmodule
